cfg_bank_writer: RTL and testbench

CFG_BANK_WRITER -- requirements
Module: cfg_bank_writer

---
 rtl/cfg_bank_writer.sv | 199 +++++++++++++++++++
 tb/tb_cfg_bank_writer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_bank_writer.sv
//------------------------------------------------------------------------------
// Module      : cfg_bank_writer
// Description : Serial-to-parallel configuration bank writer. Shifts BL_W
//               serial bits into the bit-line register, then pulses the
//               current word-line for WL_PULSE cycles, holds one guard cycle,
//               and advances to the next row until all WL_W rows are written.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cfg_bank_writer #(
  parameter int BL_W     = 8,
  parameter int WL_W     = 8,
  parameter int WL_PULSE = 2
) (
  input  logic                      prog_clk,
  input  logic                      pReset,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [BL_W-1:0]           bl,
  output logic [WL_W-1:0]           wl,
  output logic [$clog2(WL_W)-1:0]   row,
  output logic                      busy,
  output logic                      done
);

  localparam int c_BC_W = (BL_W > 1) ? $clog2(BL_W) : 1;
  localparam int c_RW   = $clog2(WL_W);

  localparam logic [c_BC_W-1:0] c_BIT_LAST   = c_BC_W'(BL_W - 1);
  localparam logic [c_RW-1:0]   c_ROW_LAST   = c_RW'(WL_W - 1);
  localparam logic [3:0]        c_PULSE_LAST = 4'(WL_PULSE - 1);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_LOAD  = 3'd1;
  localparam logic [2:0] c_ST_WRITE = 3'd2;
  localparam logic [2:0] c_ST_HOLD  = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [c_BC_W-1:0] r_bitcnt;
  logic [3:0]        r_pulse;

  logic [c_BC_W-1:0] w_bitcnt;
  logic [3:0]        w_pulse;
  logic [BL_W-1:0]   w_bl;
  logic [WL_W-1:0]   w_wl;
  logic [c_RW-1:0]   w_row;
  logic              w_ready;
  logic              w_busy;
  logic              w_done;

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; abort beats start, start is only honoured when idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_DONE: begin
        if (start) begin
          w_next = abort ? c_ST_IDLE : c_ST_LOAD;
        end
      end
      c_ST_LOAD: begin
        if (abort) begin
          w_next = c_ST_IDLE;
        end else if (din_valid && (r_bitcnt == c_BIT_LAST)) begin
          w_next = c_ST_WRITE;
        end
      end
      c_ST_WRITE: begin
        if (abort) begin
          w_next = c_ST_IDLE;
        end else if (r_pulse == c_PULSE_LAST) begin
          w_next = c_ST_HOLD;
        end
      end
      c_ST_HOLD: begin
        if (abort) begin
          w_next = c_ST_IDLE;
        end else if (row == c_ROW_LAST) begin
          w_next = c_ST_DONE;
        end else begin
          w_next = c_ST_LOAD;
        end
      end
      default: w_next = c_ST_IDLE;
    endcase
  end

  // Next values for counters and outputs; the word-line is decoded from the
  // next state so that wl can only be driven while WRITE is registered.
  always_comb begin
    w_bl     = bl;
    w_row    = row;
    w_bitcnt = r_bitcnt;
    w_pulse  = r_pulse;
    w_done   = done;
    case (r_state)
      c_ST_IDLE, c_ST_DONE: begin
        if (start) begin
          w_row    = '0;
          w_bitcnt = '0;
          w_pulse  = '0;
          w_bl     = '0;
          w_done   = 1'b0;
        end
      end
      c_ST_LOAD: begin
        if (abort) begin
          w_bitcnt = '0;
          w_pulse  = '0;
          w_bl     = '0;
        end else if (din_valid) begin
          w_bl[r_bitcnt] = din;
          w_pulse        = '0;
          if (r_bitcnt != c_BIT_LAST) begin
            w_bitcnt = r_bitcnt + 1'b1;
          end
        end
      end
      c_ST_WRITE: begin
        if (abort) begin
          w_bitcnt = '0;
          w_pulse  = '0;
          w_bl     = '0;
        end else if (r_pulse == c_PULSE_LAST) begin
          w_pulse = '0;
        end else begin
          w_pulse = r_pulse + 4'd1;
        end
      end
      c_ST_HOLD: begin
        w_bitcnt = '0;
        w_pulse  = '0;
        w_bl     = '0;
        if (!abort) begin
          if (row != c_ROW_LAST) begin
            w_row = row + 1'b1;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      default: begin
        w_row    = '0;
        w_bitcnt = '0;
        w_pulse  = '0;
        w_bl     = '0;
        w_done   = 1'b0;
      end
    endcase

    w_wl = '0;
    if (w_next == c_ST_WRITE) begin
      w_wl[w_row] = 1'b1;
    end
    w_ready = (w_next == c_ST_LOAD);
    w_busy  = (w_next == c_ST_LOAD) || (w_next == c_ST_WRITE) ||
              (w_next == c_ST_HOLD);
  end

  // Output and counter registers; everything clears while reset is held.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_bitcnt  <= '0;
      r_pulse   <= '0;
      bl        <= '0;
      wl        <= '0;
      row       <= '0;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_bitcnt  <= w_bitcnt;
      r_pulse   <= w_pulse;
      bl        <= w_bl;
      wl        <= w_wl;
      row       <= w_row;
      din_ready <= w_ready;
      busy      <= w_busy;
      done      <= w_done;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cfg_bank_writer.sv
//------------------------------------------------------------------------------
// Module      : tb_cfg_bank_writer
// Description : Self-checking bench for cfg_bank_writer (BL_W=8, WL_W=8,
//               WL_PULSE=2): a table of single-cycle vectors followed by
//               directed multi-row sequences.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cfg_bank_writer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       din;
  logic       dv;
  logic       din_ready;
  logic [7:0] bl;
  logic [7:0] wl;
  logic [2:0] row;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  bit mon_en = 1'b0;

  cfg_bank_writer #(
    .BL_W    (8),
    .WL_W    (8),
    .WL_PULSE(2)
  ) dut (
    .prog_clk (clk),
    .pReset   (rst),
    .start    (start),
    .abort    (abort),
    .din      (din),
    .din_valid(dv),
    .din_ready(din_ready),
    .bl       (bl),
    .wl       (wl),
    .row      (row),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       abort;
    logic       din;
    logic       dv;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_done;
    logic [7:0] exp_wl;
    logic [7:0] exp_bl;
    logic [2:0] exp_row;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic begin_pass();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("pass_busy",  32'(busy), 32'd1);
    chk("pass_ready", 32'(din_ready), 32'd1);
    chk("pass_row",   32'(row), 32'd0);
    chk("pass_bl",    32'(bl), 32'd0);
  endtask

  // mode 0: complete the row; 1: abort in first WRITE cycle; 2: reset there.
  task automatic do_row(input int r, input logic [7:0] data, input int stall_at, input int mode);
    logic [7:0] onehot;
    onehot = 8'd1 << r;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        dv = 1'b0;
        repeat (5) begin
          step();
          chk("stall_ready", 32'(din_ready), 32'd1);
          chk("stall_wl",    32'(wl), 32'd0);
        end
        chk("stall_bl_low", 32'(bl[2:0]), 32'(data[2:0]));
      end
      din = data[i];
      dv  = 1'b1;
      step();
      if (i < 7) begin
        chk("load_ready", 32'(din_ready), 32'd1);
        chk("load_wl",    32'(wl), 32'd0);
      end
    end
    din = 1'b0;
    chk("write_wl",    32'(wl), 32'(onehot));
    chk("write_bl",    32'(bl), 32'(data));
    chk("write_ready", 32'(din_ready), 32'd0);
    chk("write_row",   32'(row), 32'(r));
    if (mode == 1) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_wl",    32'(wl), 32'd0);
      chk("abort_bl",    32'(bl), 32'd0);
      chk("abort_busy",  32'(busy), 32'd0);
      chk("abort_done",  32'(done), 32'd0);
      chk("abort_ready", 32'(din_ready), 32'd0);
      return;
    end
    if (mode == 2) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstw_wl",   32'(wl), 32'd0);
      chk("rstw_bl",   32'(bl), 32'd0);
      chk("rstw_busy", 32'(busy), 32'd0);
      return;
    end
    step();
    chk("write2_wl", 32'(wl), 32'(onehot));
    chk("write2_bl", 32'(bl), 32'(data));
    step();
    chk("hold_wl",   32'(wl), 32'd0);
    chk("hold_bl",   32'(bl), 32'(data));
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_done", 32'(done), 32'd0);
    step();
    if (r < 7) begin
      chk("next_ready", 32'(din_ready), 32'd1);
      chk("next_row",   32'(row), 32'(r + 1));
      chk("next_bl",    32'(bl), 32'd0);
      chk("next_wl",    32'(wl), 32'd0);
    end else begin
      chk("fin_done",  32'(done), 32'd1);
      chk("fin_busy",  32'(busy), 32'd0);
      chk("fin_bl",    32'(bl), 32'd0);
      chk("fin_row",   32'(row), 32'd7);
      chk("fin_ready", 32'(din_ready), 32'd0);
    end
  endtask

  // Word-line legality on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!$onehot0(wl)) begin
        errors++;
        $display("FAIL wl_onehot: got %0h expected at most one bit", wl);
      end
      if (!busy && (wl != 8'd0)) begin
        errors++;
        $display("FAIL wl_idle: got %0h expected 0 when not busy", wl);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; din = 1'b0; dv = 1'b0;

    //            rst   start abort din   dv    rdy   busy  done  wl     bl     row
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 3'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 3'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 3'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h05, 3'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0};

    for (int k = 0; k < 12; k++) begin
      rst   = vecs[k].rst;
      start = vecs[k].start;
      abort = vecs[k].abort;
      din   = vecs[k].din;
      dv    = vecs[k].dv;
      step();
      mon_en = 1'b1;
      chk($sformatf("vec%0d_ready", k), 32'(din_ready), 32'(vecs[k].exp_ready));
      chk($sformatf("vec%0d_busy",  k), 32'(busy),      32'(vecs[k].exp_busy));
      chk($sformatf("vec%0d_done",  k), 32'(done),      32'(vecs[k].exp_done));
      chk($sformatf("vec%0d_wl",    k), 32'(wl),        32'(vecs[k].exp_wl));
      chk($sformatf("vec%0d_bl",    k), 32'(bl),        32'(vecs[k].exp_bl));
      chk($sformatf("vec%0d_row",   k), 32'(row),       32'(vecs[k].exp_row));
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; din = 1'b0; dv = 1'b0;
    step();

    // Full pass with continuous data; done appears on edge 89 counting the
    // edge that samples start as edge 1.
    edges = 0;
    begin_pass();
    for (int r = 0; r < 8; r++) begin
      do_row(r, 8'hA5 ^ 8'(r), -1, 0);
    end
    chk("full_done_latency", 32'(edges), 32'd89);

    // Five-cycle stall after the third bit of row 0.
    edges = 0;
    begin_pass();
    do_row(0, 8'h3C, 3, 0);
    chk("stall_row0_edges", 32'(edges), 32'd17);
    for (int r = 1; r < 8; r++) begin
      do_row(r, 8'h5A + 8'(r), -1, 0);
    end
    chk("stall_done_latency", 32'(edges), 32'd94);

    // Abort in WRITE of row 4, then a fresh pass from row 0.
    begin_pass();
    for (int r = 0; r < 4; r++) begin
      do_row(r, 8'h11 * 8'(r + 1), -1, 0);
    end
    do_row(4, 8'hC3, -1, 1);
    edges = 0;
    begin_pass();
    for (int r = 0; r < 8; r++) begin
      do_row(r, ~8'(r), -1, 0);
    end
    chk("reabort_done_latency", 32'(edges), 32'd89);

    // Reset held three cycles in the middle of loading row 2.
    begin_pass();
    do_row(0, 8'h01, -1, 0);
    do_row(1, 8'h02, -1, 0);
    for (int i = 0; i < 3; i++) begin
      din = 1'b1; dv = 1'b1;
      step();
    end
    chk("preRst_bl", 32'(bl), 32'h07);
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    repeat (3) begin
      step();
      chk("rst_ready", 32'(din_ready), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_wl",    32'(wl), 32'd0);
      chk("rst_bl",    32'(bl), 32'd0);
      chk("rst_row",   32'(row), 32'd0);
    end
    rst = 1'b0; start = 1'b0; dv = 1'b0; din = 1'b0;
    step();
    chk("postRst_busy", 32'(busy), 32'd0);
    begin_pass();

    // Reset during a WRITE pulse drops the word-line on the next edge.
    do_row(0, 8'h99, -1, 2);

    // start while busy in row 3 is ignored; start in DONE restarts.
    edges = 0;
    begin_pass();
    for (int r = 0; r < 3; r++) begin
      do_row(r, 8'hF0 | 8'(r), -1, 0);
    end
    start = 1'b1;
    do_row(3, 8'h6E, -1, 0);
    start = 1'b0;
    for (int r = 4; r < 8; r++) begin
      do_row(r, 8'hF0 | 8'(r), -1, 0);
    end
    chk("busyStart_latency", 32'(edges), 32'd89);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("doneStart_done",  32'(done), 32'd0);
    chk("doneStart_busy",  32'(busy), 32'd1);
    chk("doneStart_ready", 32'(din_ready), 32'd1);
    chk("doneStart_row",   32'(row), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("cleanup_busy", 32'(busy), 32'd0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("startAbort_busy",  32'(busy), 32'd0);
    chk("startAbort_done",  32'(done), 32'd0);
    chk("startAbort_ready", 32'(din_ready), 32'd0);
    step();
    chk("startAbort_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
